// File: rtl/bsr_sipo_pkg.sv
// Shared constants for the bidirectional serial-in/parallel-out shift register.
package bsr_sipo_pkg;
    localparam int   BSR_WIDTH      = 4;
    localparam logic BSR_MODE_RIGHT = 1'b0;
    localparam logic BSR_MODE_LEFT  = 1'b1;
endpackage

// File: rtl/bsr_sipo.sv
// Bidirectional SIPO shift register: one serial bit enters per clock, left or right per mode.
module bsr_sipo
    import bsr_sipo_pkg::*;
#(
    parameter int WIDTH = BSR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             mode,
    output logic [WIDTH-1:0] pout
);

    logic [WIDTH-1:0] sr;

    // Left pulls sin into bit 0, right pulls it into the MSB; the far end bit falls off.
    function automatic logic [WIDTH-1:0] shift_next(
        input logic [WIDTH-1:0] cur,
        input logic             s,
        input logic             m
    );
        if (m == BSR_MODE_LEFT)
            return {cur[WIDTH-2:0], s};
        else
            return {s, cur[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            sr <= '0;
        else
            sr <= shift_next(sr, sin, mode);
    end

    assign pout = sr;

endmodule

// File: tb/tb_bsr_sipo.sv
// Randomized and directed check of bsr_sipo at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_bsr_sipo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       mode = 1'b0;
    logic [3:0] p4;
    logic [7:0] p8;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state held as plain integers: shifting = multiply/divide by two.
    int unsigned m4 = 0;
    int unsigned m8 = 0;

    always #5 clk = ~clk;

    bsr_sipo #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .sin(sin), .mode(mode), .pout(p4));
    bsr_sipo #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .sin(sin), .mode(mode), .pout(p8));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_next(input int unsigned cur, input int w,
                                               input logic r, input logic s, input logic m);
        int unsigned span;
        span = 1 << w;
        if (r) return 0;
        if (m) return (cur * 2 + s) % span;
        return cur / 2 + (s ? span / 2 : 0);
    endfunction

    // Apply one edge with the given inputs, advance the model, compare both widths.
    task automatic step(input logic r, input logic s, input logic m);
        rst = r; sin = s; mode = m;
        @(posedge clk);
        m4 = model_next(m4, 4, r, s, m);
        m8 = model_next(m8, 8, r, s, m);
        #1;
        chk("model_w4", {28'd0, p4}, m4);
        chk("model_w8", {24'd0, p8}, m8);
    endtask

    initial begin
        // Reset held two edges with junk on sin/mode
        step(1, 1, 1); chk("rst_e1", {28'd0, p4}, 32'h0);
        step(1, 0, 0); chk("rst_e2", {28'd0, p4}, 32'h0);
        chk("rst_w8", {24'd0, p8}, 32'h0);

        // Left shift 1,0,1,0 then 1
        step(0, 1, 1); chk("left1", {28'd0, p4}, 32'h1);
        step(0, 0, 1); chk("left2", {28'd0, p4}, 32'h2);
        step(0, 1, 1); chk("left3", {28'd0, p4}, 32'h5);
        step(0, 0, 1); chk("left4", {28'd0, p4}, 32'hA);
        step(0, 1, 1); chk("left_drop", {28'd0, p4}, 32'h5);

        // Right shift 1,0,0,1 then 0
        step(1, 0, 0);
        step(0, 1, 0); chk("right1", {28'd0, p4}, 32'h8);
        step(0, 0, 0); chk("right2", {28'd0, p4}, 32'h4);
        step(0, 0, 0); chk("right3", {28'd0, p4}, 32'h2);
        step(0, 1, 0); chk("right4", {28'd0, p4}, 32'h9);
        step(0, 0, 0); chk("right_drop", {28'd0, p4}, 32'h4);

        // Direction change from 0011
        step(1, 0, 0);
        step(0, 1, 1); step(0, 1, 1); chk("dir_pre", {28'd0, p4}, 32'h3);
        step(0, 1, 1); chk("dir_left", {28'd0, p4}, 32'h7);
        step(0, 0, 0); chk("dir_right0", {28'd0, p4}, 32'h3);
        step(0, 1, 0); chk("dir_right1", {28'd0, p4}, 32'h9);

        // Reset mid-stream from 1010
        step(1, 0, 0);
        step(0, 1, 1); step(0, 0, 1); step(0, 1, 1); step(0, 0, 1);
        chk("mid_pre", {28'd0, p4}, 32'hA);
        step(1, 1, 1); chk("mid_rst", {28'd0, p4}, 32'h0);
        step(0, 1, 1); chk("mid_after", {28'd0, p4}, 32'h1);

        // Width 8: eight left 1s, then a right 0
        step(1, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 1);
        chk("w8_fill", {24'd0, p8}, 32'hFF);
        chk("w8_fill_w4", {28'd0, p4}, 32'hF);
        step(0, 0, 0);
        chk("w8_right", {24'd0, p8}, 32'h7F);
        chk("w8_right_w4", {28'd0, p4}, 32'h7);

        // Random traffic with occasional mid-stream resets
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
